d2pram_pipe: RTL

Parametrised simple-dual-port (1R1W) RAM behavioural model. It is the next generation of the team's single-cycle SRAM models and adds:
- concurrent read and write
- byte-enable writes
- configurable read latency with a valid strobe
- selectable read/write collision policy
- optional post-reset zero-initialisation sweep

It is used behind FIFOs and buffers wherever a registered-output memory macro is modelled.

---
 rtl/d2pram_pipe.sv | 135 +++++++++++++
 1 files changed

// File: rtl/d2pram_pipe.sv
// Simple-dual-port (1R1W) RAM model with byte enables, RD_LAT-deep registered read
// pipeline, selectable read/write collision policy and optional post-reset zero sweep.
module d2pram_pipe #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned SIZE      = 32,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MODE      = 0,
    parameter int unsigned INIT_ZERO = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    output logic                                   init_busy,
    input  logic                                   wen,
    input  logic [((SIZE > 1) ? $clog2(SIZE) : 1)-1:0] waddr,
    input  logic [WIDTH-1:0]                       wdata,
    input  logic [WIDTH/8-1:0]                     wbe,
    input  logic                                   ren,
    input  logic [((SIZE > 1) ? $clog2(SIZE) : 1)-1:0] raddr,
    output logic [WIDTH-1:0]                       rdata,
    output logic                                   rvalid
);

    localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned NB = WIDTH / 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   init_cnt_q, init_cnt_d;

    logic [WIDTH-1:0] mem [SIZE];

    logic             run;
    logic             wr_ok;
    logic             rd_ok;
    logic             rd_in_range;
    logic [WIDTH-1:0] rd_old;
    logic [WIDTH-1:0] rd_word;

    logic [WIDTH-1:0] pipe_data [RD_LAT];
    logic [RD_LAT-1:0] pipe_vld;

    // Init/run state register; reset re-arms the sweep when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (INIT_ZERO != 0) begin
                state_q <= ST_INIT;
            end else begin
                state_q <= ST_RUN;
            end
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Sweep one word per cycle; leave INIT on the edge that clears the last word.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == AW'(SIZE - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + AW'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign run         = (state_q == ST_RUN);
    assign wr_ok       = run && wen && (32'(waddr) < SIZE);
    assign rd_ok       = run && ren;
    assign rd_in_range = (32'(raddr) < SIZE);
    assign init_busy   = (state_q == ST_INIT);

    // Storage has no reset: contents survive rst_n and are only cleared by the sweep.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem[init_cnt_q] <= '0;
        end else if (wr_ok) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Word captured at the read edge; write-first merges same-edge enabled bytes.
    always_comb begin
        rd_old  = '0;
        rd_word = '0;
        if (rd_in_range) begin
            rd_old = mem[raddr];
        end
        rd_word = rd_old;
        if ((MODE != 0) && wr_ok && rd_in_range && (waddr == raddr)) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    rd_word[8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline; data is zeroed in invalid slots so rdata is 0 whenever rvalid is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= rd_ok;
            pipe_data[0] <= rd_ok ? rd_word : '0;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign rdata  = pipe_data[RD_LAT-1];
    assign rvalid = pipe_vld[RD_LAT-1];

endmodule
